// File: rtl/blu_pkg.sv
// Shared types and constants for the bitwise logic unit.
package blu_pkg;

    typedef enum logic [2:0] {
        BLU_AND     = 3'd0,
        BLU_OR      = 3'd1,
        BLU_XOR     = 3'd2,
        BLU_NOR     = 3'd3,
        BLU_NAND    = 3'd4,
        BLU_XNOR    = 3'd5,
        BLU_ACC_OR  = 3'd6,
        BLU_ACC_AND = 3'd7
    } blu_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } blu_state_e;

    localparam logic [2:0] OP_ACC_OR  = 3'd6;
    localparam logic [2:0] OP_ACC_AND = 3'd7;

    // True for the two multi-beat accumulate opcodes.
    function automatic logic is_acc_op(input logic [2:0] op);
        return (op == OP_ACC_OR) || (op == OP_ACC_AND);
    endfunction

endpackage

// File: rtl/blu_op_core.sv
// Combinational per-bit function f(op, a, b). The accumulate opcodes map to
// their per-beat contribution: a|b for ACC_OR, a&b for ACC_AND.
module blu_op_core
    import blu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  blu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    // Select the bitwise function for the current opcode.
    always_comb begin
        f = '0;
        case (op)
            BLU_AND:     f = a & b;
            BLU_OR:      f = a | b;
            BLU_XOR:     f = a ^ b;
            BLU_NOR:     f = ~(a | b);
            BLU_NAND:    f = ~(a & b);
            BLU_XNOR:    f = ~(a ^ b);
            BLU_ACC_OR:  f = a | b;
            BLU_ACC_AND: f = a & b;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Handshaked bitwise logic unit with OR/AND multi-beat accumulation.
// Optional build macro: BLU_FLAGS_EN registers out_zero/out_ones alongside
// out_data; without it both flag ports are tied to 0.
//
// state | meaning
// IDLE  | no accumulation open
// ACCUM | accumulation open; acc, cnt and acc_op are valid
module bitwise_logic_unit
    import blu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_zero,
    output logic             out_ones
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    blu_state_e       state;
    logic [2:0]       acc_op;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [2:0]       op_sel;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] result_beats;
    logic             produces_out;
    logic             accept;

    // While accumulating, the stored op drives the core and the live op is ignored.
    assign op_sel = (state == ACCUM) ? acc_op : op;

    blu_op_core #(.WIDTH(WIDTH)) u_core (
        .op (blu_op_e'(op_sel)),
        .a  (a),
        .b  (b),
        .f  (f)
    );

    assign v        = (acc_op == OP_ACC_AND) ? (acc & f) : (acc | f);
    assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Only beats that load the output register wait on the output stage.
    assign produces_out = (state == ACCUM) ? last : (!is_acc_op(op) || last);
    assign in_ready     = produces_out ? (!out_valid || out_ready) : 1'b1;
    assign accept       = in_valid && in_ready;

    assign result       = (state == ACCUM) ? v : f;
    assign result_beats = (state == ACCUM) ? cnt_next : CNT_ONE;

    // FSM, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_op    <= OP_ACC_OR;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
        end else begin
            if (accept && produces_out) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_beats <= result_beats;
                state     <= IDLE;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && !produces_out) begin
                if (state == IDLE) begin
                    acc    <= f;
                    cnt    <= CNT_ONE;
                    acc_op <= op;
                    state  <= ACCUM;
                end else begin
                    acc <= v;
                    cnt <= cnt_next;
                end
            end
        end
    end

`ifdef BLU_FLAGS_EN
    // Flags are captured in the same cycle as the result they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
            out_ones <= 1'b0;
        end else if (accept && produces_out) begin
            out_zero <= (result == '0);
            out_ones <= &result;
        end
    end
`else
    assign out_zero = 1'b0;
    assign out_ones = 1'b0;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Bench for bitwise_logic_unit: two instances (CNT_W=8 and CNT_W=2) share the
// stimulus; a sequence-level model predicts every output each cycle.
module tb_bitwise_logic_unit;

`ifdef BLU_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       last;
    logic       out_ready;

    logic       rdy8, ov8, z8, o8;
    logic [7:0] od8, ob8;
    logic       rdy2, ov2, z2, o2;
    logic [7:0] od2;
    logic [1:0] ob2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
        .op(op), .a(a), .b(b), .last(last), .out_valid(ov8),
        .out_ready(out_ready), .out_data(od8), .out_beats(ob8),
        .out_zero(z8), .out_ones(o8)
    );

    bitwise_logic_unit #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .op(op), .a(a), .b(b), .last(last), .out_valid(ov2),
        .out_ready(out_ready), .out_data(od2), .out_beats(ob2),
        .out_zero(z2), .out_ones(o2)
    );

    // ---------------- model ----------------
    bit         m_valid;
    logic [7:0] m_data;
    int         m_beats;
    bit         m_zero, m_ones;
    bit         m_open;
    logic [2:0] m_op;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    function automatic logic [7:0] bitop(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x | y);
            3'd4: return ~(x & y);
            default: return ~(x ^ y);
        endcase
    endfunction

    // Fold the whole recorded sequence from its identity value.
    function automatic logic [7:0] fold_seq(input logic [2:0] o);
        logic [7:0] r;
        r = (o == 3'd7) ? 8'hFF : 8'h00;
        foreach (qa[i]) r = (o == 3'd7) ? (r & qa[i] & qb[i]) : (r | qa[i] | qb[i]);
        return r;
    endfunction

    function automatic bit model_needs_out();
        return m_open ? last : ((op < 3'd6) || last);
    endfunction

    function automatic bit model_ready();
        return model_needs_out() ? (!m_valid || out_ready) : 1'b1;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_data = 8'h00; m_beats = 0; m_zero = 0; m_ones = 0;
            m_open = 0; m_op = 3'd0; qa.delete(); qb.delete();
        end else begin
            bit acc_now, needs;
            needs   = model_needs_out();
            acc_now = in_valid && model_ready();
            if (acc_now && needs) begin
                if (!m_open && op < 3'd6) begin
                    m_data  = bitop(op, a, b);
                    m_beats = 1;
                end else begin
                    if (!m_open) m_op = op;
                    qa.push_back(a); qb.push_back(b);
                    m_data  = fold_seq(m_op);
                    m_beats = qa.size();
                    qa.delete(); qb.delete();
                    m_open = 0;
                end
                m_valid = 1;
                m_zero  = (m_data == 8'h00);
                m_ones  = (m_data == 8'hFF);
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (acc_now && !needs) begin
                if (!m_open) begin
                    m_open = 1; m_op = op;
                end
                qa.push_back(a); qb.push_back(b);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-low-phase.
    always @(negedge clk) begin
        #2;
        chk("in_ready8", {31'd0, rdy8}, {31'd0, model_ready()});
        chk("in_ready2", {31'd0, rdy2}, {31'd0, model_ready()});
        chk("out_valid8", {31'd0, ov8}, {31'd0, m_valid});
        chk("out_valid2", {31'd0, ov2}, {31'd0, m_valid});
        chk("out_data8", {24'd0, od8}, {24'd0, m_data});
        chk("out_data2", {24'd0, od2}, {24'd0, m_data});
        chk("out_beats8", {24'd0, ob8}, sat(m_beats, 255));
        chk("out_beats2", {30'd0, ob2}, sat(m_beats, 3));
        chk("out_zero8", {31'd0, z8}, {31'd0, FLAGS_EN & m_zero});
        chk("out_ones8", {31'd0, o8}, {31'd0, FLAGS_EN & m_ones});
        chk("out_zero2", {31'd0, z2}, {31'd0, FLAGS_EN & m_zero});
        chk("out_ones2", {31'd0, o2}, {31'd0, FLAGS_EN & m_ones});
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb, input logic xl);
        int n;
        @(negedge clk);
        in_valid = 1; op = o; a = xa; b = xb; last = xl;
        #1;
        n = 0;
        while (!rdy8 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!rdy8) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
        end else begin
            @(posedge clk);
        end
        #1 in_valid = 0;
    endtask

    task automatic expect_lit(input string nm, input logic [7:0] d, input int b8, input int b2);
        @(negedge clk); #2;
        chk({nm, "_valid"}, {31'd0, ov8}, 32'd1);
        chk({nm, "_data"}, {24'd0, od8}, {24'd0, d});
        chk({nm, "_beats8"}, {24'd0, ob8}, b8);
        chk({nm, "_beats2"}, {30'd0, ob2}, b2);
    endtask

    // Offer an output-producing beat while the output is stalled, then release.
    task automatic stalled_beat(input string nm, input logic [2:0] o, input logic [7:0] xa,
                                input logic [7:0] xb, input logic xl, input logic [7:0] held,
                                input logic [7:0] d, input int bt);
        @(negedge clk);
        in_valid = 1; op = o; a = xa; b = xb; last = xl;
        #2 chk({nm, "_blocked"}, {31'd0, rdy8}, 32'd0);
        @(negedge clk); #2;
        chk({nm, "_held"}, {24'd0, od8}, {24'd0, held});
        chk({nm, "_held_valid"}, {31'd0, ov8}, 32'd1);
        @(negedge clk);
        out_ready = 1;
        #1 chk({nm, "_released"}, {31'd0, rdy8}, 32'd1);
        @(posedge clk);
        #1 in_valid = 0; out_ready = 0;
        expect_lit(nm, d, bt, bt);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; op = 3'd0; a = 8'h00; b = 8'h00; last = 0; out_ready = 1;
        @(negedge clk); #2;
        chk("rst_in_ready", {31'd0, rdy8}, 32'd1);
        chk("rst_out_valid", {31'd0, ov8}, 32'd0);
        chk("rst_out_beats", {24'd0, ob8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        send(3'd1, 8'hA0, 8'h0C, 0);  expect_lit("or",   8'hAC, 1, 1);
        send(3'd4, 8'hFF, 8'hFF, 0);  expect_lit("nand", 8'h00, 1, 1);
        chk("nand_zero", {31'd0, z8}, FLAGS_EN ? 32'd1 : 32'd0);
        send(3'd0, 8'hA5, 8'h0F, 1);  expect_lit("and",  8'h05, 1, 1);
        send(3'd3, 8'h01, 8'h02, 0);  expect_lit("nor",  8'hFC, 1, 1);
        send(3'd5, 8'hF0, 8'hFF, 0);  expect_lit("xnor", 8'hF0, 1, 1);
        send(3'd2, 8'h3C, 8'h0F, 0);  expect_lit("xor",  8'h33, 1, 1);

        send(3'd6, 8'h01, 8'h00, 0);
        send(3'd6, 8'h00, 8'h10, 0);
        @(negedge clk); #2 chk("acc_no_out", {31'd0, ov8}, 32'd0);
        send(3'd6, 8'h80, 8'h00, 1);  expect_lit("acc_or3", 8'h91, 3, 3);

        send(3'd7, 8'hF0, 8'hFF, 0);
        send(3'd0, 8'h3C, 8'hFF, 1);  expect_lit("acc_and2", 8'h30, 2, 2);

        send(3'd6, 8'h12, 8'h21, 1);  expect_lit("acc_single", 8'h33, 1, 1);

        for (int i = 0; i < 5; i++) send(3'd6, 8'(1 << i), 8'h00, i == 4);
        expect_lit("acc_sat", 8'h1F, 5, 3);

        send(3'd7, 8'hFF, 8'hFF, 0);
        send(3'd7, 8'hFF, 8'hFF, 1);  expect_lit("acc_ones", 8'hFF, 2, 2);
        chk("acc_ones_flag", {31'd0, o8}, FLAGS_EN ? 32'd1 : 32'd0);

        // Output stall: plain op, then an accumulate that continues past the stall.
        @(negedge clk) out_ready = 0;
        send(3'd1, 8'h33, 8'h44, 0);  expect_lit("stall_first", 8'h77, 1, 1);
        stalled_beat("stall_xor", 3'd2, 8'hFF, 8'h0F, 0, 8'h77, 8'hF0, 1);
        send(3'd6, 8'h01, 8'h02, 0);
        stalled_beat("stall_acc", 3'd2, 8'h40, 8'h00, 1, 8'hF0, 8'h43, 2);
        @(negedge clk) out_ready = 1;

        // Reset in the middle of an accumulation discards it.
        send(3'd6, 8'h0F, 8'h00, 0);
        send(3'd6, 8'hF0, 8'h00, 0);
        @(negedge clk) rst_n = 0;
        #2;
        chk("midrst_valid", {31'd0, ov8}, 32'd0);
        chk("midrst_ready", {31'd0, rdy8}, 32'd1);
        @(negedge clk) rst_n = 1;
        send(3'd1, 8'h00, 8'h01, 0);  expect_lit("post_rst", 8'h01, 1, 1);

        repeat (3) @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
